// File: rtl/hilo_md_pkg.sv
// Shared definitions for the HI/LO multiply/divide sequencer: op encodings,
// controller states and small arithmetic helpers.
package hilo_md_pkg;

    localparam int MD_ITER = 32;

    localparam logic [2:0] MD_MULT  = 3'd0;
    localparam logic [2:0] MD_MULTU = 3'd1;
    localparam logic [2:0] MD_DIV   = 3'd2;
    localparam logic [2:0] MD_DIVU  = 3'd3;
    localparam logic [2:0] MD_MTHI  = 3'd4;
    localparam logic [2:0] MD_MTLO  = 3'd5;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        FIX  = 2'd2
    } md_state_t;

    function automatic logic md_is_muldiv(input logic [2:0] code);
        case (code)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: return 1'b1;
            default:                            return 1'b0;
        endcase
    endfunction

    // Magnitude of a signed operand; 0x80000000 maps onto itself as unsigned.
    function automatic logic [31:0] md_abs(input logic [31:0] v, input logic sgn);
        if (sgn && v[31]) begin
            return 32'd0 - v;
        end else begin
            return v;
        end
    endfunction

endpackage

// File: rtl/md_shift_core.sv
// Iterative unsigned datapath: shift-add multiply into a 64-bit accumulator, or
// restoring shift-subtract divide with {remainder, quotient} sharing the same register.
module md_shift_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        load,
    input  logic        step,
    input  logic        div,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [63:0] acc
);

    logic [63:0] acc_r;
    logic [31:0] opnd_r;
    logic        div_r;
    logic [32:0] msum_s;
    logic [32:0] shl_s;
    logic        ge_s;
    logic [31:0] rsub_s;
    logic [63:0] acc_nxt_s;

    // One iteration of either algorithm, selected by the latched mode.
    always_comb begin
        msum_s    = {1'b0, acc_r[63:32]} + (acc_r[0] ? {1'b0, opnd_r} : 33'd0);
        shl_s     = {acc_r[63:32], acc_r[31]};
        ge_s      = (shl_s >= {1'b0, opnd_r});
        rsub_s    = shl_s[31:0] - opnd_r;
        acc_nxt_s = acc_r;
        if (!div_r) begin
            acc_nxt_s = {msum_s, acc_r[31:1]};
        end else if (ge_s) begin
            acc_nxt_s = {rsub_s, acc_r[30:0], 1'b1};
        end else begin
            acc_nxt_s = {shl_s[31:0], acc_r[30:0], 1'b0};
        end
    end

    // Operand load on accept, then one step per CALC cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc_r  <= 64'd0;
            opnd_r <= 32'd0;
            div_r  <= 1'b0;
        end else if (load) begin
            div_r  <= div;
            opnd_r <= div ? opb : opa;
            acc_r  <= {32'd0, (div ? opa : opb)};
        end else if (step) begin
            acc_r  <= acc_nxt_s;
        end
    end

    assign acc = acc_r;

endmodule

// File: rtl/hilo_md_ctrl.sv
// HI/LO owner: sequences MULT/MULTU/DIV/DIVU through the shift core, applies
// sign fix-up, and handles single-cycle MTHI/MTLO writes.
module hilo_md_ctrl
    import hilo_md_pkg::*;
#(
    parameter int ITER = MD_ITER
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [2:0]  op,
    input  logic [31:0] a,
    input  logic [31:0] b,
    input  logic        flush,
    output logic        busy,
    output logic        done,
    output logic [31:0] hi,
    output logic [31:0] lo
);

    localparam int CW = $clog2(ITER);
    localparam logic [CW-1:0] LAST = CW'(ITER - 1);

    md_state_t   state_r, state_nxt_s;
    logic [CW-1:0] cnt_r;
    logic        load_s, step_s, commit_s, mthi_s, mtlo_s, busy_s;
    logic        is_div_s, sgn_s;
    logic        is_div_r, neg_r, rneg_r, dz_r;
    logic [31:0] a_r, hi_r, lo_r;
    logic        done_r;
    logic [63:0] acc_s, prod_s;
    logic [31:0] quo_s, rem_s, fix_hi_s, fix_lo_s;

    // Next-state and per-cycle control; flush always wins over start and commit.
    always_comb begin
        state_nxt_s = state_r;
        load_s      = 1'b0;
        step_s      = 1'b0;
        commit_s    = 1'b0;
        mthi_s      = 1'b0;
        mtlo_s      = 1'b0;
        busy_s      = 1'b0;
        case (state_r)
            IDLE: begin
                if (start && !flush) begin
                    if (md_is_muldiv(op)) begin
                        load_s      = 1'b1;
                        busy_s      = 1'b1;
                        state_nxt_s = CALC;
                    end else if (op == MD_MTHI) begin
                        mthi_s = 1'b1;
                    end else if (op == MD_MTLO) begin
                        mtlo_s = 1'b1;
                    end else begin
                        state_nxt_s = IDLE;
                    end
                end else begin
                    state_nxt_s = IDLE;
                end
            end
            CALC: begin
                busy_s = 1'b1;
                if (flush) begin
                    state_nxt_s = IDLE;
                end else begin
                    step_s = 1'b1;
                    if (cnt_r == LAST) begin
                        state_nxt_s = FIX;
                    end else begin
                        state_nxt_s = CALC;
                    end
                end
            end
            FIX: begin
                busy_s      = 1'b1;
                commit_s    = !flush;
                state_nxt_s = IDLE;
            end
            default: begin
                state_nxt_s = IDLE;
            end
        endcase
    end

    // Operand decode at accept.
    always_comb begin
        is_div_s = (op == MD_DIV) || (op == MD_DIVU);
        sgn_s    = (op == MD_MULT) || (op == MD_DIV);
    end

    md_shift_core u_core (
        .clk   (clk),
        .rst_n (rst_n),
        .load  (load_s),
        .step  (step_s),
        .div   (is_div_s),
        .opa   (md_abs(a, sgn_s)),
        .opb   (md_abs(b, sgn_s)),
        .acc   (acc_s)
    );

    // Sign correction of the unsigned core result.
    always_comb begin
        prod_s   = neg_r ? (64'd0 - acc_s) : acc_s;
        quo_s    = neg_r ? (32'd0 - acc_s[31:0]) : acc_s[31:0];
        rem_s    = rneg_r ? (32'd0 - acc_s[63:32]) : acc_s[63:32];
        fix_hi_s = prod_s[63:32];
        fix_lo_s = prod_s[31:0];
        if (!is_div_r) begin
            fix_hi_s = prod_s[63:32];
            fix_lo_s = prod_s[31:0];
        end else if (dz_r) begin
            fix_hi_s = a_r;
            fix_lo_s = 32'hFFFF_FFFF;
        end else begin
            fix_hi_s = rem_s;
            fix_lo_s = quo_s;
        end
    end

    // Controller state, iteration counter and latched operation attributes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r  <= IDLE;
            cnt_r    <= '0;
            is_div_r <= 1'b0;
            neg_r    <= 1'b0;
            rneg_r   <= 1'b0;
            dz_r     <= 1'b0;
            a_r      <= 32'd0;
        end else begin
            state_r <= state_nxt_s;
            if (load_s) begin
                cnt_r    <= '0;
                is_div_r <= is_div_s;
                neg_r    <= sgn_s & (a[31] ^ b[31]);
                rneg_r   <= sgn_s & a[31];
                dz_r     <= (b == 32'd0);
                a_r      <= a;
            end else if (step_s) begin
                cnt_r <= cnt_r + CW'(1);
            end
        end
    end

    // Architectural HI/LO and the done pulse.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            hi_r   <= 32'd0;
            lo_r   <= 32'd0;
            done_r <= 1'b0;
        end else begin
            done_r <= commit_s;
            if (commit_s) begin
                hi_r <= fix_hi_s;
                lo_r <= fix_lo_s;
            end else if (mthi_s) begin
                hi_r <= a;
            end else if (mtlo_s) begin
                lo_r <= a;
            end
        end
    end

    assign busy = busy_s;
    assign done = done_r;
    assign hi   = hi_r;
    assign lo   = lo_r;

endmodule

// File: doc/hilo_md_ctrl.md
# hilo_md_ctrl

Multi-cycle multiply/divide sequencer that owns the architectural HI/LO register pair. It sits beside the single-cycle ALU in the EX stage and executes MULT/MULTU/DIV/DIVU iteratively over 34 cycles, and MTHI/MTLO in a single cycle. It raises a stall (`busy`) to the pipeline while an operation is in flight and exposes HI/LO to the ALU for MFHI/MFLO.

## Interface
Parameters:
- `ITER`, default 32: iteration count of the shift core. Fixed at 32 for MIPS32. Sizes the 5-bit counter.

Ports:
- `clk`  in  1  rising-edge clock
- `rst_n`  in  1  asynchronous, active-low reset
- `start`  in  1  EX stage presents a HI/LO-class instruction this cycle
- `op`  in  3  `MD_MULT`, `MD_MULTU`, `MD_DIV`, `MD_DIVU`, `MD_MTHI`, `MD_MTLO` (package encodings)
- `a`  in  32  rs operand (dividend / multiplicand / MTxx source)
- `b`  in  32  rt operand (divisor / multiplier)
- `flush`  in  1  exception/flush from later stage; aborts in-flight op
- `busy`  out  1  stall request to pipeline
- `done`  out  1  one-cycle pulse: mult/div result committed to HI/LO
- `hi`  out  32  HI register
- `lo`  out  32  LO register

## Operation
- States `IDLE`, `CALC`, `FIX`.
- **IDLE**:
  - `start` with MTHI/MTLO: `hi`/`lo` ← `a` at the next edge; the other register is unchanged; stays in IDLE.
  - `start` with a mult/div op: latches operands, op and sign flags, then goes to CALC with counter = 0.
  - Signed ops latch absolute values (two's complement). 0x80000000 is kept as unsigned 0x80000000.
- **CALC**: one iteration per cycle. The counter increments each cycle, and after iteration 31 the state moves to FIX.
  - Multiply: shift-add into a 64-bit accumulator.
  - Divide: restoring shift-subtract; 32-bit remainder and 32-bit quotient.
- **FIX**: applies sign correction, commits `hi`/`lo`, asserts `done` for one cycle, and returns to IDLE.
  - Product: negated if the operand signs differ.
  - Quotient: negated if the signs differ.
  - Remainder: takes the sign of the dividend.
  - Commit: mult → {hi,lo} = 64-bit product; div → lo = quotient, hi = remainder.
- Division by zero (DIV/DIVU): lo = 0xFFFFFFFF, hi = `a`. Normal latency; no sign fix-up.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0 (natural wrap, no trap).
- `busy` = (state ≠ IDLE) | (state == IDLE & `start` & op is mult/div & !`flush`). It is combinational so the issuing cycle already stalls. MTHI/MTLO never raise `busy`.
- `start` outside IDLE is ignored.
- `flush`:
  - In any state, forces IDLE at the next edge. HI/LO are unchanged and no `done` is issued.
  - `flush` together with `start` in IDLE: flush wins and nothing is written.
- Reset (any time, including mid-op): state = IDLE, counter = 0, `hi` = 0, `lo` = 0, `done` = 0, `busy` = 0 (given `start` low). No partial result is committed.

## Timing
- Accept edge E0 (IDLE, `start`). CALC covers the cycles after E0 through E32. FIX is the cycle after E32. HI/LO update and `done` assert at edge E33.
- `done` is high for exactly one cycle, beginning at E33.
- `busy` is high from the issue cycle through the FIX cycle, and low in the cycle where `done` is high.
- The mult/div latency from accept to visible HI/LO is 33 edges. Back-to-back issue is allowed in the `done` cycle.
- MTHI/MTLO: the value is visible on `hi`/`lo` one edge after issue.
- No forwarding: an MFHI in the cycle of an MTHI write reads the old value. Hazard handling is the pipeline's job.

## Structure
- The shared package (alongside the ALU control defines) holds:
  - `MD_*` op encodings (3-bit)
  - `md_state_t` (IDLE/CALC/FIX)
  - `MD_ITER` constant
- One sub-module, `md_shift_core`: the iterative datapath (accumulator, remainder/quotient shift, add/subtract per step).
- The controller FSM, sign latching, fix-up, and the HI/LO registers stay in `hilo_md_ctrl`.

## Test plan
- MULT a=0xFFFFFFFD (−3), b=5 → `done` at E33; hi=0xFFFFFFFF, lo=0xFFFFFFF1; `busy` high in the issue cycle through FIX.
- MULTU a=b=0xFFFFFFFF → hi=0xFFFFFFFE, lo=0x00000001.
- DIV a=0xFFFFFFF9 (−7), b=2 → lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- DIVU a=0x1234, b=0 → lo=0xFFFFFFFF, hi=0x00001234.
- MTHI a=0xA5A5A5A5 → hi=0xA5A5A5A5 next edge, lo unchanged, `busy` never high. Then DIVU 100/7 with `flush` at E10 → IDLE at E11, no `done`, hi/lo unchanged.
- MULT 6×7 with `rst_n` low at E20 → hi=lo=0, state IDLE immediately, no `done`. A new MULT 6×7 after reset → lo=42, hi=0.
